// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file geometry and scoreboard counter operation encoding
package riscv_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic [1:0] {CNT_HOLD, CNT_INC, CNT_DEC, CNT_CLR} cnt_op_e;
  // Flush wins; a simultaneous increment and decrement cancel out.
  function automatic cnt_op_e cnt_op(input logic clr, input logic inc, input logic dec);
    return clr ? CNT_CLR : (inc && !dec) ? CNT_INC : (dec && !inc) ? CNT_DEC : CNT_HOLD;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_counter.sv
// sb_counter: saturating pending-write counter for one architectural register
module sb_counter
  import riscv_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         full
);
  cnt_op_e op;
  always_comb op = cnt_op(clr, inc && !full, dec && nonzero);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (op == CNT_CLR) count <= '0;
    else if (op == CNT_INC) count <= count + 1'b1;
    else if (op == CNT_DEC) count <= count - 1'b1;
  end
  assign nonzero = |count;
  assign full = &count;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write scoreboard; define SCOREBOARD_STALL_CNT_EN for stall_cycles
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic                  stall,
`ifdef SCOREBOARD_STALL_CNT_EN
  output logic [31:0]           stall_cycles,
`endif
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  underflow_err
);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nz, fl;
  logic issue_fire;
  assign cnt[0] = '0;
  assign nz[0] = 1'b0;
  assign fl[0] = 1'b0;
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(issue_fire && issue_rd == REG_ADDR_W'(i)),
      .dec(wb_valid && wb_rd == REG_ADDR_W'(i)),
      .clr(flush),
      .count(cnt[i]),
      .nonzero(nz[i]),
      .full(fl[i])
    );
  end
  // Only registered counts feed stall, so a same-cycle writeback cannot release it.
  always_comb begin
    stall = !rst && issue_valid &&
            ((use_rs1 && cnt[rs1] != '0) || (use_rs2 && cnt[rs2] != '0) ||
             (issue_we && issue_rd != '0 && fl[issue_rd]));
    issue_fire = issue_valid && issue_we && !stall && issue_rd != '0;
  end
  assign busy_mask = nz;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underflow_err <= 1'b0;
    else if (wb_valid && wb_rd != '0 && !nz[wb_rd]) underflow_err <= 1'b1;
  end
`ifdef SCOREBOARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end
`endif
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port issue_valid  input  1  decode-stage instruction presented for issue.
REQ-005 SHALL have port issue_we  input  1  presented instruction writes rd.
REQ-006 SHALL have port issue_rd  input  5  destination register address.
REQ-007 SHALL have ports rs1, rs2  input  5 each  source register addresses.
REQ-008 SHALL have ports use_rs1, use_rs2  input  1 each  source actually read.
REQ-009 SHALL have port wb_valid  input  1  writeback retiring a register write this cycle.
REQ-010 SHALL have port wb_rd  input  5  writeback destination address.
REQ-011 SHALL have port flush  input  1  pipeline drained; discard all pending state.
REQ-012 SHALL have port stall  output  1  hold decode; issue not accepted.
REQ-013 SHALL have port busy_mask  output  32  bit i set when register i has a pending write.
REQ-014 SHALL have port underflow_err  output  1  sticky writeback-without-pending error.

Function
REQ-015 SHALL keep one CNT_W-bit counter per register 1..31; register 0 has no counter and busy_mask[0] is constantly 0.
REQ-016 SHALL assert stall combinationally when issue_valid and (use_rs1 and cnt[rs1]!=0, or use_rs2 and cnt[rs2]!=0, or issue_we and issue_rd!=0 and cnt[issue_rd] is at its maximum 2^CNT_W-1).
REQ-017 SHALL compute stall from registered counters only; a same-cycle writeback does not clear a stall (the register-file write lands at the edge).
REQ-018 SHALL define issue_fire = issue_valid & issue_we & !stall & (issue_rd!=0); issue_fire increments cnt[issue_rd] at the next edge.
REQ-019 SHALL decrement cnt[wb_rd] at the next edge when wb_valid and wb_rd!=0 and cnt[wb_rd]!=0.
REQ-020 SHALL leave the counter unchanged when issue_fire and a valid decrement target the same register in the same cycle.
REQ-021 SHALL, on wb_valid with wb_rd!=0 and cnt[wb_rd]==0, leave the counter at 0 and set underflow_err, which holds until reset.
REQ-022 SHALL ignore wb_valid with wb_rd==0 and issue with issue_rd==0 (no count change, no error).
REQ-023 SHALL, on flush, clear all counters at the next edge, with flush overriding same-cycle issue and writeback; underflow_err is not cleared by flush.
REQ-024 SHALL drive busy_mask[i] = (cnt[i]!=0), registered-state derived, visible the cycle after the causing edge.

Reset
REQ-025 SHALL, while rst is high, immediately force all counters to 0, busy_mask to 0, and underflow_err to 0, independent of clk.
REQ-026 SHALL, while rst is high, force stall to 0, taking precedence over any in-flight issue.

Configuration
REQ-027 SHALL, when macro SCOREBOARD_STALL_CNT_EN is defined, add output stall_cycles (32-bit) counting cycles with stall high, saturating at 0xFFFFFFFF, reset to 0 by rst and unaffected by flush.
REQ-028 SHALL, when SCOREBOARD_STALL_CNT_EN is undefined, omit the stall_cycles port and its counter entirely.

Structure
REQ-029 SHALL take REG_ADDR_W (5) and NUM_REGS (32) from the shared package riscv_pkg; CNT_W remains a module parameter.
REQ-030 SHALL implement each per-register counter as one instance of sub-module sb_counter (inc, dec, clr, count, nonzero, full), generated for registers 1..31.

Verification
REQ-031 Issue x5 write (issue_rd=5, issue_we=1) -> next cycle busy_mask=0x00000020; following issue with rs1=5, use_rs1=1 -> stall=1.
REQ-032 Three issues to x7 then a fourth -> fourth stalls (count 3, CNT_W=2); one wb_rd=7 -> count 2, busy_mask[7] still 1.
REQ-033 Same cycle issue_fire x9 and wb_valid wb_rd=9 with count 1 -> count stays 1; a stalled rs1=9 read in that cycle stays stalled.
REQ-034 wb_valid wb_rd=12 with count 0 -> underflow_err=1, persists through flush, cleared only by rst.
REQ-035 Counts pending on x3,x4 plus flush with simultaneous issue to x6 -> next cycle busy_mask=0.
REQ-036 Assert rst asynchronously mid-cycle with busy_mask nonzero -> busy_mask=0 and stall=0 before the next edge; with SCOREBOARD_STALL_CNT_EN, 4 stall cycles -> stall_cycles=4.
